// File: rtl/mux_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin arbiter that steers a 1-bit-per-requester data bus through a
//   generic mux. The current owner keeps the grant while it keeps requesting.
//   On release, the grant moves straight to the next requester in
//   round-robin order with no idle cycle. With no requests, the arbiter
//   goes idle.
//
//   Optional feature: define MUX_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD
//   consecutive cycles whenever some other requester is waiting.
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   synchronous active-low reset
//   req    in   [INS-1:0] per-requester request
//   w      in   [INS-1:0] per-requester data bit
//   gnt    out  [INS-1:0] registered one-hot grant (or zero)
//   s      out  [$clog2(INS)-1:0] registered mux select / owner index
//   valid  out  registered, high while a grant is held
//   f      out  w[s] gated by valid
// ---------------------------------------------------------------------------

// Generic INS:1 single-bit mux. An out-of-range select yields 0, so the
// non-power-of-two case is well defined.
module mux_generic_1bit #(
  parameter int INS = 4,
  parameter int SW  = $clog2(INS)
) (
  input  logic [INS-1:0] in_i,
  input  logic [SW-1:0]  sel_i,
  output logic           out_o
);
  logic [INS-1:0] hit;

  for (genvar i = 0; i < INS; i++) begin : g_sel
    assign hit[i] = in_i[i] && (sel_i == SW'(i));
  end

  assign out_o = |hit;
endmodule

module mux_rr_arbiter #(
  parameter int INS      = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INS-1:0]         req,
  input  logic [INS-1:0]         w,
  output logic [INS-1:0]         gnt,
  output logic [$clog2(INS)-1:0] s,
  output logic                   valid,
  output logic                   f
);
  localparam int SW = $clog2(INS);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  s_q, s_d;
  logic [SW-1:0]  ptr_q, ptr_d;
  logic [INS-1:0] gnt_q, gnt_d;
  logic           valid_q, valid_d;
  logic [SW-1:0]  win_ptr, win_own;
  logic           keep;
  logic           mux_out;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          others;
`endif

  // First set request strictly after base, wrapping; base itself is checked
  // last, so a lone request from the base index still wins.
  function automatic logic [SW-1:0] rr_pick(input logic [SW-1:0]  base,
                                            input logic [INS-1:0] r);
    logic [SW-1:0] pick;
    logic          found;
    int            idx;
    pick  = base;
    found = 1'b0;
    for (int k = 1; k <= INS; k++) begin
      idx = int'(base) + k;
      if (idx >= INS) idx = idx - INS;
      if (!found && r[idx]) begin
        pick  = SW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign win_ptr = rr_pick(ptr_q, req);
  assign win_own = rr_pick(s_q, req);

`ifdef MUX_ARB_TIMEOUT_EN
  // Someone other than the current owner is waiting.
  assign others = |(req & ~gnt_q);
  assign keep   = req[s_q] && !((hold_cnt_q == HOLD_LAST) && others);
`else
  assign keep   = req[s_q];
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          s_d     = win_ptr;
          ptr_d   = win_ptr;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (keep) begin
`ifdef MUX_ARB_TIMEOUT_EN
          // Saturate so a lone owner can hold forever.
          if (hold_cnt_q != HOLD_LAST) hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end else if (|req) begin
          // Hand over at this edge; the owner's own bit is either clear or
          // scanned last, so another requester wins.
          s_d   = win_own;
          ptr_d = win_own;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          state_d = IDLE;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == GRANT);
    gnt_d   = valid_d ? (INS'(1) << s_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      ptr_q   <= SW'(INS - 1);
      gnt_q   <= '0;
      valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  mux_generic_1bit #(.INS(INS)) u_mux (
    .in_i  (w),
    .sel_i (s_q),
    .out_o (mux_out)
  );

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign f     = mux_out & valid_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter (INS=4, MAX_HOLD=4). A behavioural model tracks the
// owner as an integer and is compared with the DUT every cycle. Directed
// scenarios pin the model with literal expectations.
module tb_mux_rr_arbiter;
  localparam int INS      = 4;
  localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [INS-1:0] req, w, gnt;
  logic [1:0]     s;
  logic           valid, f;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mux_rr_arbiter #(.INS(INS), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .w(w),
    .gnt(gnt), .s(s), .valid(valid), .f(f)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: owner index (-1 = nobody), last owner, hold age
  int m_owner = -1;
  int m_last  = INS - 1;
  int m_s     = 0;
  int m_hold  = 0;

  function automatic int next_rr(input int base, input logic [INS-1:0] r);
    for (int k = 1; k <= INS; k++)
      if (r[(base + k) % INS]) return (base + k) % INS;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_last = INS - 1; m_s = 0; m_hold = 0;
    end else if (m_owner < 0) begin
      if (req != 0) begin
        m_owner = next_rr(m_last, req);
        m_hold  = 0;
      end
    end else begin
      logic waiting;
      waiting = (req & ~(INS'(1) << m_owner)) != 0;
      if (req[m_owner] && !(TMO && m_hold == MAX_HOLD - 1 && waiting)) begin
        if (m_hold < MAX_HOLD - 1) m_hold++;
      end else if (req != 0) begin
        m_owner = next_rr(m_owner, req);
        m_hold  = 0;
      end else begin
        m_owner = -1;
      end
    end
    if (m_owner >= 0) begin
      m_s = m_owner; m_last = m_owner;
    end
  end

  // ---- per-cycle compare against the model
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("gnt",    int'(gnt),   m_owner >= 0 ? (1 << m_owner) : 0);
      chk("s",      int'(s),     m_s);
      chk("valid",  int'(valid), m_owner >= 0 ? 1 : 0);
      chk("f",      int'(f),     m_owner >= 0 ? int'(w[m_s]) : 0);
      chk("onehot", int'($countones(gnt) <= 1), 1);
      chk("s_range", int'(s < INS), 1);
    end
  end

  task automatic step();
    @(posedge clk); #3;
  endtask

  task automatic drive(input logic r, input logic [INS-1:0] rq, input logic [INS-1:0] wd);
    @(negedge clk);
    rst_n = r; req = rq; w = wd;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; w = '0;
    step(); step();
    chk_en = 1'b1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_s", int'(s), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_f", int'(f), 0);

    // first grant goes to requester 0
    drive(1'b1, 4'b0101, 4'b1010); step();
    chk("first_gnt", int'(gnt), 4'b0001);
    chk("first_s", int'(s), 0);
    chk("first_valid", int'(valid), 1);
    chk("first_f", int'(f), 0);

    // owner 0 releases -> 2 without bubble
    drive(1'b1, 4'b0100, 4'b1010); step();
    chk("move_gnt", int'(gnt), 4'b0100);
    chk("move_s", int'(s), 2);
    chk("move_f0", int'(f), 0);
    drive(1'b1, 4'b0100, 4'b0100); step();
    chk("move_f1", int'(f), 1);

    // reset mid-grant
    drive(1'b0, 4'b0100, 4'b0100); step();
    chk("midrst_gnt", int'(gnt), 0);
    chk("midrst_s", int'(s), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_f", int'(f), 0);
    drive(1'b1, 4'b1000, 4'b0000); step();
    chk("post_rst_gnt", int'(gnt), 4'b1000);
    chk("post_rst_s", int'(s), 3);

    // requests vanish: idle, s retained
    drive(1'b1, 4'b0000, 4'b1111); step();
    chk("idle_valid", int'(valid), 0);
    chk("idle_f", int'(f), 0);
    chk("idle_s", int'(s), 3);
    for (int i = 0; i < 9; i++) step();
    chk("idle_s_held", int'(s), 3);
    chk("idle_gnt", int'(gnt), 0);

    // all requesting, each owner releases after 2 cycles: 0,1,2,3,0
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      drive(1'b1, 4'b1111, 4'b0110); step();
      for (int g = 0; g < 5; g++) begin
        chk("rr_order", int'(s), order[g]);
        chk("rr_valid1", int'(valid), 1);
        drive(1'b1, 4'b1111, 4'b0110); step();
        chk("rr_hold", int'(s), order[g]);
        chk("rr_valid2", int'(valid), 1);
        if (g < 4) begin
          drive(1'b1, 4'b1111 & ~(4'b0001 << order[g]), 4'b0110); step();
        end
      end
    end

    // two constant requesters: timeout rotation or indefinite hold
    drive(1'b0, 4'b0000, 4'b0000); step();
    drive(1'b1, 4'b0011, 4'b0001); step();
    for (int k = 0; k < 16; k++) begin
      int exp_own;
      exp_own = TMO ? (k / MAX_HOLD) % 2 : 0;
      chk("hold_gnt", int'(gnt), 1 << exp_own);
      step();
    end

    // lone requester never loses the grant
    drive(1'b1, 4'b0100, 4'b0100);
    for (int k = 0; k < 10; k++) step();
    chk("lone_gnt", int'(gnt), 4'b0100);
    chk("lone_f", int'(f), 1);

    // randomized traffic against the model
    begin
      logic [INS-1:0] rq;
      rq = '0;
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(0, 9) < 3) rq = INS'($urandom_range(0, (1 << INS) - 1));
        drive(($urandom_range(0, 63) != 0), rq, INS'($urandom));
        step();
      end
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter INS, default 4, number of requesters and mux inputs; legal range 2..32, power of two not required.
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, maximum consecutive grant cycles per owner when MUX_ARB_TIMEOUT_EN is defined; legal range >= 1.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port req, input, INS, per-requester request; bit i is requester i.
REQ-006 The block SHALL have port w, input, INS, per-requester data bit.
REQ-007 The block SHALL have port gnt, output, INS, registered one-hot grant, or all-zero.
REQ-008 The block SHALL have port s, output, $clog2(INS), registered mux select and index of the current owner.
REQ-009 The block SHALL have port valid, output, 1, registered; high while a grant is held.
REQ-010 The block SHALL have port f, output, 1; f = w[s] when valid=1, else 0.

Function
REQ-011 The data path SHALL be one instance of mux_generic_1bit #(.INS(INS)) driven by w and s, with its output ANDed with valid to form f.
REQ-012 The FSM SHALL have two states: IDLE (gnt=0, valid=0) and GRANT (gnt=1<<s, valid=1).
REQ-013 Arbitration SHALL be round-robin: the winner is the first set req bit scanning upward from ptr+1, wrapping from INS-1 to 0, where ptr is the index of the last owner.
REQ-014 In IDLE with req!=0 at an edge, the FSM SHALL enter GRANT at that edge with s=winner, giving 1-cycle latency from sampled req to visible gnt.
REQ-015 In IDLE with req==0, s SHALL hold its previous value and the FSM SHALL remain in IDLE.
REQ-016 In GRANT, the owner SHALL keep the grant while req[s]=1, subject to REQ-023.
REQ-017 In GRANT, when req[s]=0 is sampled and another req bit is set, the grant SHALL move to the round-robin winner after s at that same edge, with no idle bubble.
REQ-018 In GRANT, when req[s]=0 is sampled and req==0, the FSM SHALL enter IDLE at that edge.
REQ-019 ptr SHALL update to the new owner on every grant change.
REQ-020 gnt SHALL never have more than one bit set, and gnt!=0 SHALL occur only when valid=1.
REQ-021 s SHALL never exceed INS-1, including when INS is not a power of two.

Reset
REQ-022 When rst_n=0 at a clock edge, the block SHALL set: state=IDLE, gnt=0, s=0, valid=0, ptr=INS-1 (requester 0 wins first), hold_cnt=0; f=0 as a consequence; reset mid-grant drops the grant at that edge regardless of req.

Configuration
REQ-023 With macro MUX_ARB_TIMEOUT_EN defined, the block SHALL hold a hold_cnt that is zeroed on each grant change and incremented each GRANT cycle.
REQ-024 With MUX_ARB_TIMEOUT_EN defined, when hold_cnt==MAX_HOLD-1 and another req bit is set, the grant SHALL rotate to the round-robin winner at that edge even though req[s]=1.
REQ-025 With MUX_ARB_TIMEOUT_EN defined and no other requester pending, the owner SHALL keep the grant and hold_cnt SHALL saturate.
REQ-026 With MUX_ARB_TIMEOUT_EN undefined, no hold_cnt logic SHALL exist and the owner SHALL hold indefinitely while req[s]=1.

Verification (INS=4, MAX_HOLD=4)
REQ-027 Scenario: after reset, req=4'b0101 and w=4'b1010 -> after one edge gnt=0001, s=0, valid=1, f=0.
REQ-028 Scenario: owner 0 drops, req=4'b0100 -> next edge gnt=0100, s=2, f=w[2]=0; then w=4'b0100 -> f=1.
REQ-029 Scenario: req=4'b1111, each owner releases after 2 cycles and re-requests -> grant order 0,1,2,3,0, no cycle with valid=0.
REQ-030 Scenario: req=4'b0011 held constant -> with macro defined, gnt=0001 for 4 cycles then 0010 for 4 cycles, alternating; without macro, gnt=0001 indefinitely.
REQ-031 Scenario: rst_n=0 for one edge while gnt=0100 -> gnt=0, s=0, valid=0, f=0; then req=4'b1000 -> gnt=1000 and s=3 one edge later.
REQ-032 Scenario: req=0 for 10 cycles from GRANT -> IDLE after the first edge, valid=0, f=0, s unchanged.
